// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan path: FSM encoding, digit count
// and the active-low hex segment table ({g,f,e,d,c,b,a}).
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry [n] is the active-low pattern for hex value n (leftmost entry is F).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex to active-low seven-segment decode.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_multiplexer.sv
// Registered four-way digit selector; digit follows a select change by one cycle.
module seg_multiplexer
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] select,
  input  logic [3:0] val_a,
  input  logic [3:0] val_b,
  input  logic [3:0] val_c,
  input  logic [3:0] val_d,
  output logic [3:0] digit
);

  logic [NUM_DIGITS-1:0][3:0] vals;
  logic [NUM_DIGITS-1:0][3:0] masked;
  logic [3:0]                 digit_next;
  logic [3:0]                 digit_reg;

  assign vals = {val_d, val_c, val_b, val_a};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_mask
      assign masked[gi] = select[gi] ? vals[gi] : 4'h0;
    end
  endgenerate

  assign digit_next = masked[0] | masked[1] | masked[2] | masked[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_reg <= 4'h0;
    end else begin
      digit_reg <= digit_next;
    end
  end

  assign digit = digit_reg;

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed display scanner: each slot is BLANK dark cycles followed
// by PRESCALE-BLANK lit cycles, so the registered decode has settled before the anode lights.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit,
  output logic [3:0] select,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t             state_reg,  state_next;
  logic [CNT_W-1:0]   count_reg,  count_next;
  logic [1:0]         index_reg,  index_next;
  logic [3:0]         select_reg, select_next;
  logic [3:0]         an_reg,     an_next;
  logic [6:0]         seg_reg,    seg_next;
  logic [6:0]         seg_dec;

  seg_decoder u_dec (
    .hex (digit),
    .seg (seg_dec)
  );

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    index_next  = index_reg;
    select_next = select_reg;
    an_next     = an_reg;
    seg_next    = seg_dec;

    if (!enable) begin
      state_next  = ST_IDLE;
      count_next  = '0;
      index_next  = 2'd0;
      select_next = digit_onehot(2'd0);
      an_next     = 4'hF;
      seg_next    = SEG_BLANK;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next  = ST_BLANK;
          count_next  = '0;
          index_next  = 2'd0;
          select_next = digit_onehot(2'd0);
          an_next     = 4'hF;
        end
        ST_BLANK: begin
          count_next = count_reg + CNT_W'(1);
          an_next    = 4'hF;
          if (count_reg == CNT_W'(BLANK - 1)) begin
            state_next = ST_SHOW;
            an_next    = ~select_reg;
          end
        end
        ST_SHOW: begin
          if (count_reg == CNT_W'(PRESCALE - 1)) begin
            // index is 2 bits wide, so D rolls straight back to A
            state_next  = ST_BLANK;
            count_next  = '0;
            index_next  = index_reg + 2'd1;
            select_next = digit_onehot(index_reg + 2'd1);
            an_next     = 4'hF;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next  = ST_IDLE;
          count_next  = '0;
          index_next  = 2'd0;
          select_next = digit_onehot(2'd0);
          an_next     = 4'hF;
          seg_next    = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      index_reg  <= 2'd0;
      select_reg <= 4'b0001;
      an_reg     <= 4'hF;
      seg_reg    <= SEG_BLANK;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      index_reg  <= index_next;
      select_reg <= select_next;
      an_reg     <= an_next;
      seg_reg    <= seg_next;
    end
  end

  assign select = select_reg;
  assign an     = an_reg;
  assign seg    = seg_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: scanner paired with the digit multiplexer, PRESCALE=6, BLANK=2.
module tb_seg_scan_driver;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] val_a, val_b, val_c, val_d;
  logic [3:0] digit;
  logic [3:0] select;
  logic [3:0] an;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  // Hand-computed per-slot expectations for A=4 B=3 C=2 D=1.
  logic [3:0] sel_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] an_exp  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_exp [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] dec_exp [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(.PRESCALE(6), .BLANK(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .digit  (digit),
    .select (select),
    .an     (an),
    .seg    (seg)
  );

  seg_multiplexer u_mux (
    .clk    (clk),
    .reset  (reset),
    .select (select),
    .val_a  (val_a),
    .val_b  (val_b),
    .val_c  (val_c),
    .val_d  (val_d),
    .digit  (digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, want, $time);
    end else begin
      $display("ok   %s: %0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_sel"}, 32'(select), 32'h1);
    check_val({tag, "_an"},  32'(an),     32'hF);
    check_val({tag, "_seg"}, 32'(seg),    32'h7F);
  endtask

  // k counts edges since scanning (re)started; k=0 is the first BLANK cycle of slot A.
  task automatic scan_check(input int n, input int k0);
    int k, slot, pos;
    logic [3:0] prev_sel;
    prev_sel = select;
    for (int i = 0; i < n; i++) begin
      k = k0 + i;
      step();
      slot = (k / 6) % 4;
      pos  = k % 6;
      check_val("scan_sel", 32'(select), 32'(sel_exp[slot]));
      if (pos == 0 && slot == 0 && k > 0)
        check_val("wrap_prev_sel", 32'(prev_sel), 32'h8);
      if (pos < 2) begin
        check_val("scan_an_blank", 32'(an), 32'hF);
      end else begin
        check_val("scan_an_show", 32'(an), 32'(an_exp[slot]));
        check_val("scan_seg", 32'(seg), 32'(seg_exp[slot]));
      end
      prev_sel = select;
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    val_a  = 4'h4;
    val_b  = 4'h3;
    val_c  = 4'h2;
    val_d  = 4'h1;

    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("reset");
    end

    // Release reset: BLANK on the first edge, two full frames with wrap.
    reset = 1'b0;
    scan_check(48, 0);

    // Run into slot C, drop enable on its third lit cycle.
    scan_check(17, 48);
    enable = 1'b0;
    step();
    check_idle("en_drop");
    step();
    check_idle("en_hold");

    // Re-enable restarts at slot A with a full blank interval.
    enable = 1'b1;
    scan_check(10, 0);

    // Reset during slot B SHOW while enable stays high.
    reset = 1'b1;
    step();
    check_idle("mid_reset");
    reset = 1'b0;
    scan_check(24, 0);

    // Decode sweep on slot A.
    for (int v = 0; v < 16; v++) begin
      reset = 1'b1;
      val_a = 4'(v);
      step();
      reset = 1'b0;
      step();
      step();
      step();
      check_val($sformatf("dec_an_%0h", v), 32'(an), 32'hE);
      check_val($sformatf("dec_seg_%0h", v), 32'(seg), 32'(dec_exp[v]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter PRESCALE, default 1000; clock cycles per digit slot; SHALL be greater than BLANK.
REQ-002 Parameter BLANK, default 2; blanking cycles at the start of each slot; SHALL be at least 2.
REQ-003 clk  input  1  system clock; the block has one clock, and all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  scanning runs when 1; outputs blank and the block idles when 0.
REQ-006 digit  input  4  hex value returned by seg_multiplexer for the current select; valid one cycle after select changes.
REQ-007 select  output  4  one-hot digit select driven to seg_multiplexer; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-008 an  output  4  active-low anode enables, bit order matching select.
REQ-009 seg  output  7  active-low segments, order {g,f,e,d,c,b,a}.

Function
REQ-010 States: IDLE, BLANK, SHOW; state, slot counter (0..PRESCALE-1), index (0..3) and all outputs SHALL be registered.
REQ-011 IDLE: select=4'b0001, an=4'hF, counter=0, index=0; enable=1 -> BLANK on the next edge.
REQ-012 BLANK: counter increments each cycle; when counter reaches BLANK-1 the state SHALL go to SHOW on the next edge.
REQ-013 SHOW: counter increments each cycle; when counter reaches PRESCALE-1, on the next edge counter->0, index->(index+1) mod 4, select->one-hot of the new index, state->BLANK.
REQ-014 Wrap-around: index 3 SHALL advance to 0 (select 4'b1000 -> 4'b0001) with no extra cycle.
REQ-015 select SHALL always be exactly one-hot, including during reset and IDLE.
REQ-016 an SHALL be ~select while in SHOW, and 4'hF in BLANK and IDLE.
REQ-017 seg SHALL be the registered hex decode of digit, updated every enabled cycle; latency is digit->seg 1 cycle and select->seg 2 cycles, which BLANK>=2 covers.
REQ-018 Decode table (hex, active-low) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-019 enable=0 in any state SHALL force IDLE on the next edge: an=4'hF, seg=7'h7F, counter and index cleared; this applies mid-slot and mid-SHOW.
REQ-020 Re-enable SHALL always restart at index 0 with a full BLANK interval.
REQ-021 Each slot SHALL last exactly PRESCALE cycles; the full frame SHALL be 4*PRESCALE cycles.

Reset
REQ-022 reset=1 at an edge SHALL force IDLE, select=4'b0001, an=4'hF, seg=7'h7F, counter=0, index=0; reset overrides enable.
REQ-023 Deasserting reset with enable=1 SHALL enter BLANK on the first following edge.

Structure
REQ-024 Shared package seg_pkg SHALL hold the state encoding, the 16-entry segment table, SEG_BLANK=7'h7F and the digit count (4).
REQ-025 The hex-to-segment decode SHALL be a combinational sub-module, seg_decoder (4-bit in, 7-bit active-low out), that the block instantiates and then registers.
REQ-026 The bench SHALL pair the block with seg_multiplexer (select->select, digit<-digit) as the system under test.

Verification
REQ-027 Reset: reset=1 for 3 cycles, enable=1 -> select=0001, an=F, seg=7F; BLANK entered 1 cycle after reset falls.
REQ-028 Scan: PRESCALE=6, BLANK=2, A=4 B=3 C=2 D=1 -> per slot, an=E/D/B/7 with seg=19/30/24/79 for 4 cycles, an=F for 2 cycles.
REQ-029 Wrap: run 2 frames -> select 1000 followed directly by 0001; every slot exactly 6 cycles.
REQ-030 Enable drop: enable=0 at SHOW cycle 3 of slot C -> next edge an=F, seg=7F, select=0001; re-enable -> slot A with 2 blank cycles.
REQ-031 Reset mid-SHOW in slot B -> IDLE values on the next edge, regardless of enable.
REQ-032 Decode sweep: hold A at 0..F in turn -> seg matches the REQ-018 table exactly.
